alu_issue_stage: RTL

//  ID/EX issue stage feeding the ALU. Decodes opcode/funct3/funct7[5] into ALUControl, selects SrcA/SrcB
//  (with MEM/WB forwarding), registers into the ID/EX pipeline register under stall/flush control.

---
 rtl/alu_issue_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes ALU control, selects operands and registers them under stall/flush.
// Optional MEM/WB operand forwarding is enabled by defining ISSUE_FWD_EN.
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [6:0]       id_op,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_rd1,
  input  logic [XLEN-1:0]  id_rd2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_result,
  output logic             ex_valid,
  output logic [2:0]       ex_alu_control,
  output logic [XLEN-1:0]  ex_src_a,
  output logic [XLEN-1:0]  ex_src_b,
  output logic [4:0]       ex_rd,
  output logic             ex_regwrite,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] issue_count
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;

  alu_ctrl_e       dec_ctrl;
  logic            dec_regwrite;
  logic            dec_illegal;
  logic            dec_use_imm;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  always_comb begin
    dec_ctrl     = ALU_ADD;
    dec_regwrite = 1'b0;
    dec_illegal  = 1'b0;
    dec_use_imm  = 1'b0;
    case (id_op)
      OP_LW: begin
        dec_use_imm  = 1'b1;
        dec_regwrite = 1'b1;
      end
      OP_SW:  dec_use_imm = 1'b1;
      OP_BEQ: dec_ctrl = ALU_SUB;
      OP_R, OP_I: begin
        dec_use_imm  = (id_op == OP_I);
        dec_regwrite = 1'b1;
        case (id_funct3)
          3'b000:  dec_ctrl = (id_op == OP_R && id_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  dec_ctrl = ALU_SLT;
          3'b110:  dec_ctrl = ALU_OR;
          3'b111:  dec_ctrl = ALU_AND;
          default: begin
            dec_illegal  = 1'b1;
            dec_regwrite = 1'b0;
          end
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

`ifdef ISSUE_FWD_EN
  // MEM is the younger producer, so it takes precedence over WB; x0 is never forwarded.
  always_comb begin
    fwd_a = id_rd1;
    if (mem_regwrite && mem_rd == id_rs1 && id_rs1 != 5'd0)
      fwd_a = mem_result;
    else if (wb_regwrite && wb_rd == id_rs1 && id_rs1 != 5'd0)
      fwd_a = wb_result;
  end

  always_comb begin
    fwd_b = id_rd2;
    if (mem_regwrite && mem_rd == id_rs2 && id_rs2 != 5'd0)
      fwd_b = mem_result;
    else if (wb_regwrite && wb_rd == id_rs2 && id_rs2 != 5'd0)
      fwd_b = wb_result;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{id_rs1, id_rs2, mem_regwrite, mem_rd, mem_result,
                        wb_regwrite, wb_rd, wb_result};
  assign fwd_a = id_rd1;
  assign fwd_b = id_rd2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid       <= 1'b0;
      ex_alu_control <= '0;
      ex_src_a       <= '0;
      ex_src_b       <= '0;
      ex_rd          <= '0;
      ex_regwrite    <= 1'b0;
      ex_illegal     <= 1'b0;
      issue_count    <= '0;
    end else if (flush || (!stall && !id_valid)) begin
      ex_valid       <= 1'b0;
      ex_alu_control <= '0;
      ex_src_a       <= '0;
      ex_src_b       <= '0;
      ex_rd          <= '0;
      ex_regwrite    <= 1'b0;
      ex_illegal     <= 1'b0;
    end else if (!stall) begin
      ex_valid       <= 1'b1;
      ex_alu_control <= dec_ctrl;
      ex_src_a       <= fwd_a;
      ex_src_b       <= dec_use_imm ? id_imm : fwd_b;
      ex_rd          <= id_rd;
      ex_regwrite    <= dec_regwrite;
      ex_illegal     <= dec_illegal;
      issue_count    <= issue_count + CNT_W'(1);
    end
  end

endmodule
